// File: rtl/cpu_pkg.sv
// Shared CPU package: sequencer state encoding
// and register/word constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } bts_state_e;

  localparam logic [3:0] REG_PC = 4'd15;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/block_transfer_seq_lsb_prio_enc.sv
// Lowest-set-bit priority encoder for 16-bit lists.
// idx is 0 when the input is empty.
module lsb_prio_enc (
  input  logic [15:0] in,
  output logic [3:0]  idx,
  output logic        valid
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    idx   = '0;
    valid = |in;
    for (int i = 15; i >= 0; i--) begin
      if (in[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/block_transfer_seq.sv
// LDM/STM block transfer sequencer.
// Optional abort support: define BTS_ABORT_EN.
module block_transfer_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       reg_list,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
`ifdef BTS_ABORT_EN
  input  logic              mem_abort,
  output logic              aborted,
`endif
  output logic [3:0]        rb_read_select,
  input  logic [ADDR_W-1:0] rb_read_data,
  output logic [3:0]        rb_write_select,
  output logic              rb_write_en,
  output logic [ADDR_W-1:0] rb_write_data
);

  localparam logic [ADDR_W-1:0] WB =
    ADDR_W'(WORD_BYTES);

  bts_state_e        state, state_n;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] addr_q, fin_q;
  logic              load_q, wbok_q, abt_q;
  logic [3:0]        breg_q;
  logic [3:0]        cur;
  logic              cur_v;
  logic              last;
  logic              abort_w;
  logic [4:0]        cnt;
  logic [ADDR_W-1:0] span, first_a, final_a;

`ifdef BTS_ABORT_EN
  assign abort_w = mem_abort;
  assign aborted = (state == FIN) && abt_q;
`else
  assign abort_w = 1'b0;
`endif

  lsb_prio_enc u_enc (
    .in    (list_q),
    .idx   (cur),
    .valid (cur_v)
  );

  assign last = (list_q & ~(16'd1 << cur)) == '0;

  // transfer count and start/final addresses
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(reg_list[i]);
    end
    span = ADDR_W'(cnt) * WB;
    unique case ({up, pre})
      2'b11:   first_a = base_addr + WB;
      2'b10:   first_a = base_addr;
      2'b01:   first_a = base_addr - span;
      default: first_a = base_addr - span + WB;
    endcase
    final_a = up ? base_addr + span
                 : base_addr - span;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // latched transfer context and walking address
  always_ff @(posedge clk) begin
    if (reset) begin
      list_q <= '0;
      addr_q <= '0;
      fin_q  <= '0;
      load_q <= 1'b0;
      wbok_q <= 1'b0;
      abt_q  <= 1'b0;
      breg_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          list_q <= reg_list;
          addr_q <= first_a;
          fin_q  <= final_a;
          load_q <= is_load;
          breg_q <= base_reg;
          abt_q  <= 1'b0;
          wbok_q <= writeback
                 && (reg_list != '0)
                 && !(is_load
                      && reg_list[base_reg]);
        end
        XFER: if (mem_ack) begin
          list_q <= list_q & ~(16'd1 << cur);
          addr_q <= addr_q + WB;
          if (abort_w) begin
            list_q <= '0;
            abt_q  <= 1'b1;
            wbok_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // next state and bus/register-port outputs
  always_comb begin
    state_n         = state;
    busy            = state != IDLE;
    done            = state == FIN;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = addr_q;
    mem_wdata       = '0;
    rb_read_select  = cur;
    rb_write_en     = 1'b0;
    rb_write_select = '0;
    rb_write_data   = '0;
    unique case (state)
      IDLE: if (start) begin
        state_n = (reg_list != '0) ? XFER : FIN;
      end
      XFER: begin
        mem_req = cur_v;
        mem_we  = cur_v && !load_q;
        if (mem_we) mem_wdata = rb_read_data;
        if (load_q && mem_ack
            && !abort_w && !reset) begin
          rb_write_en     = 1'b1;
          rb_write_select = cur;
          rb_write_data   = mem_rdata;
        end
        if (mem_ack && (abort_w || last))
          state_n = FIN;
      end
      FIN: begin
        state_n = IDLE;
        if (wbok_q && !reset) begin
          rb_write_en     = 1'b1;
          rb_write_select = breg_q;
          rb_write_data   = fin_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/block_transfer_seq.md
# block_transfer_seq

Multi-cycle sequencer for ARM load/store-multiple (LDM/STM) transfers. It owns the register bank's C read port and its main write port for the whole transfer. It walks a 16-bit register list lowest-first, issuing one word access per register on the data memory handshake, then optionally writes the updated base back. It sits between the decode/control unit, which starts it, and the register bank and memory interface; the control unit stalls while `busy` is high.

## Interface
- `ADDR_W`, default 32: address and data width.
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `start  in  1`: request pulse. Sampled only in IDLE.
- `is_load  in  1`: 1 = LDM, 0 = STM.
- `up  in  1`: 1 = increment, 0 = decrement addressing.
- `pre  in  1`: 1 = pre-index, 0 = post-index.
- `writeback  in  1`: write the final base back to `base_reg`.
- `base_reg  in  4`: base register number.
- `base_addr  in  ADDR_W`: base register value.
- `reg_list  in  16`: bit i set = transfer Ri.
- `busy  out  1`: high while not IDLE.
- `done  out  1`: one-cycle completion pulse.
- `mem_req  out  1`, `mem_we  out  1`: memory access request and write enable.
- `mem_addr  out  ADDR_W`: word address of the current access.
- `mem_wdata  out  ADDR_W`: store data.
- `mem_ack  in  1`, `mem_rdata  in  ADDR_W`: memory access acknowledge and load data.
- `rb_read_select  out  4`, `rb_read_data  in  ADDR_W`: register bank C port (asynchronous read).
- `rb_write_select  out  4`, `rb_write_en  out  1`, `rb_write_data  out  ADDR_W`: register bank write port.

## Operation
- States:
  - IDLE
  - XFER
  - FIN
- Start handling:
  - IDLE, `start`=1 and `reg_list`≠0: latch all inputs, go to XFER.
  - IDLE, `start`=1 and `reg_list`=0: go to FIN with no memory access and writeback suppressed.
  - `start` outside IDLE is ignored.
- Transfer count and addresses:
  - n = popcount(`reg_list`).
  - Lowest register always uses the lowest address; addresses ascend by 4.
  - First address: IA = base, IB = base+4, DA = base−4n+4, DB = base−4n.
  - Final base: up = base+4n, down = base−4n.
  - All address arithmetic is modulo 2^ADDR_W, wrapping silently.
- XFER:
  - Current register = lowest set bit of the remaining list.
  - `mem_req`=1 and `mem_we`=!is_load. `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ack`.
  - STM: `rb_read_select`=current register, `mem_wdata`=`rb_read_data` (combinational pass-through).
  - LDM: in the `mem_ack` cycle, `rb_write_en`=1, `rb_write_select`=current register, `rb_write_data`=`mem_rdata`.
  - On `mem_ack`: clear the bit, address += 4. If that was the last bit, go to FIN.
- FIN, exactly one cycle:
  - `done`=1.
  - If `writeback` is set, and the transfer is not an LDM whose `reg_list` contains `base_reg` (the loaded value wins): `rb_write_en`=1, `rb_write_select`=`base_reg`, `rb_write_data`=final base.
  - Then go to IDLE.
- Register values:
  - STM of `base_reg` stores the original base, because writeback happens only in FIN.
  - LDM including R15 writes R15 through the normal write port. The register bank gives that write priority over its PC-increment write.

## Timing
- Reset values, all zero: state IDLE, `busy`, `done`, `mem_req`, `mem_we`, `rb_write_en`, `mem_addr`, `mem_wdata`, `rb_write_data`, `rb_read_select`, `rb_write_select`.
- `start` accepted at cycle T:
  - `busy` and `mem_req` go high at T+1.
  - With `mem_ack` tied high, one transfer per cycle: n transfers occupy T+1..T+n, `done` is at T+n+1 and `busy` drops at T+n+2.
- Empty list: `done` at T+1, `mem_req` never asserted.
- Back-to-back: `mem_req` stays high across consecutive transfers, with the address advancing the cycle after `mem_ack`.
- `reset` mid-transfer: IDLE next cycle, no further register writes, no `done`, and no writeback.
- Outputs other than the combinational pass-throughs are registered.

## Configuration
- `BTS_ABORT_EN` defined:
  - Adds input `mem_abort` (valid with `mem_ack`) and output `aborted`.
  - An abort cycle performs no register write and jumps to FIN.
  - FIN then asserts `done` and `aborted` together, with writeback suppressed.
- Undefined: neither port exists and every acknowledged access completes normally.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (IDLE/XFER/FIN),
  - `REG_PC` = 4'd15,
  - `WORD_BYTES` = 4.
- Sub-module `lsb_prio_enc`: 16-bit input, outputs a 4-bit index of the lowest set bit plus `valid`. It is used for the current-register select. Popcount stays inline.

## Test plan
- STM IA, base=0x100, list=0x0013, writeback, ack tied high:
  - stores R0, R1 and R4 to 0x100, 0x104 and 0x108;
  - base written as 0x10C;
  - `done` at T+4.
- LDM DB, base=0x200, list=0x8001, ack delayed 2 cycles each:
  - address 0x1F8 loads R0, address 0x1FC loads R15;
  - final base 0x1F8;
  - `mem_addr` stable while waiting.
- LDM IA with writeback, base_reg=2, list=0x0004: R2 gets `mem_rdata`, and no FIN writeback occurs.
- Empty list, start: `done` at T+1, no `mem_req`, no `rb_write_en`.
- Reset asserted during the 2nd of 4 transfers: IDLE next cycle, no further writes, no `done`.
- With `BTS_ABORT_EN`, abort on the 2nd of 3 loads:
  - first register is written, second is not;
  - `done` and `aborted` asserted together;
  - no writeback.
